// File: rtl/outpkt_result_arbiter_pkg.sv
// Shared packet constants and types for the result arbiter.
// Field widths and type codes live beside RAM_ADDR_MSB.
package outpkt_result_arbiter_pkg;

  localparam int RAM_ADDR_MSB = 4;

  localparam int PKT_ID_W  = 16;
  localparam int WORD_ID_W = 16;
  localparam int GEN_ID_W  = 32;
  localparam int NUM_W     = 32;
  localparam int HASH_W    = RAM_ADDR_MSB + 1;

  localparam logic [1:0] PKT_CMP_EQUAL   = 2'b01;
  localparam logic [1:0] PKT_PACKET_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_DRAIN
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/outpkt_result_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first request at or after ptr_i,
// wrapping from N-1 back to 0.
module rr_priority_pick
  import outpkt_result_arbiter_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/outpkt_result_arbiter.sv
// Result arbiter: round-robin CMP_EQUAL hits from the units,
// PACKET_DONE once all units have drained for DRAIN_CYCLES.
module outpkt_result_arbiter
  import outpkt_result_arbiter_pkg::*;
#(
  parameter int N_UNITS      = 8,
  parameter int PKT_TYPE_MSB = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic [N_UNITS-1:0]           unit_valid,
  output logic [N_UNITS-1:0]           unit_ack,
  input  logic [PKT_ID_W*N_UNITS-1:0]  unit_pkt_id,
  input  logic [WORD_ID_W*N_UNITS-1:0] unit_word_id,
  input  logic [GEN_ID_W*N_UNITS-1:0]  unit_gen_id,
  input  logic [HASH_W*N_UNITS-1:0]    unit_hash_num,
  input  logic [N_UNITS-1:0]           unit_idle,
  input  logic                         done_valid,
  input  logic [PKT_ID_W-1:0]          done_pkt_id,
  input  logic [NUM_W-1:0]             done_num,
  output logic                         done_ack,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic [PKT_TYPE_MSB:0]        pkt_type,
  output logic [PKT_ID_W-1:0]          pkt_id,
  output logic [WORD_ID_W-1:0]         word_id,
  output logic [GEN_ID_W-1:0]          gen_id,
  output logic [NUM_W-1:0]             num_processed,
  output logic [HASH_W-1:0]            hash_num_eq
);

  localparam int IW = idx_w(N_UNITS);
  localparam int TW = PKT_TYPE_MSB + 1;
  localparam int QW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [TW-1:0] TYPE_CMP  = TW'(PKT_CMP_EQUAL);
  localparam logic [TW-1:0] TYPE_DONE = TW'(PKT_PACKET_DONE);
  localparam logic [QW-1:0] QUIET_LAST = QW'(DRAIN_CYCLES - 1);
  localparam logic [IW-1:0] PTR_LAST   = IW'(N_UNITS - 1);

  arb_state_e           state_q;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
  logic [N_UNITS-1:0]   unit_ack_q;
  logic                 done_ack_q;
  logic                 wr_en_q;
  logic [TW-1:0]        type_q;
  logic [PKT_ID_W-1:0]  pkt_id_q;
  logic [WORD_ID_W-1:0] word_id_q;
  logic [GEN_ID_W-1:0]  gen_id_q;
  logic [NUM_W-1:0]     num_q;
  logic [HASH_W-1:0]    hash_q;

  logic [N_UNITS-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 any_valid;
  logic                 quiet;

  logic [PKT_ID_W-1:0]  sel_pkt_id;
  logic [WORD_ID_W-1:0] sel_word_id;
  logic [GEN_ID_W-1:0]  sel_gen_id;
  logic [HASH_W-1:0]    sel_hash;

  rr_priority_pick #(
    .N  (N_UNITS),
    .IW (IW)
  ) u_pick (
    .req_i   (unit_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (any_valid)
  );

  // One-hot AND-OR select of the granted unit's hit fields.
  always_comb begin
    sel_pkt_id  = '0;
    sel_word_id = '0;
    sel_gen_id  = '0;
    sel_hash    = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (pick_oh[i]) begin
        sel_pkt_id  = unit_pkt_id[i*PKT_ID_W +: PKT_ID_W];
        sel_word_id = unit_word_id[i*WORD_ID_W +: WORD_ID_W];
        sel_gen_id  = unit_gen_id[i*GEN_ID_W +: GEN_ID_W];
        sel_hash    = unit_hash_num[i*HASH_W +: HASH_W];
      end
    end
  end

  assign quiet    = (&unit_idle) & ~any_valid;
  assign rr_ptr_d = (pick_idx == PTR_LAST) ? '0
                  : pick_idx + IW'(1);
  assign quiet_cnt_d = quiet ? quiet_cnt_q + QW'(1) : '0;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      quiet_cnt_q <= '0;
      unit_ack_q  <= '0;
      done_ack_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      type_q      <= '0;
      pkt_id_q    <= '0;
      word_id_q   <= '0;
      gen_id_q    <= '0;
      num_q       <= '0;
      hash_q      <= '0;
    end else begin
      unit_ack_q <= '0;
      done_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          quiet_cnt_q <= '0;
          if (any_valid)       state_q <= S_GRANT;
          else if (done_valid) state_q <= S_DRAIN;
        end
        S_GRANT: begin
          if (any_valid) begin
            type_q     <= TYPE_CMP;
            pkt_id_q   <= sel_pkt_id;
            word_id_q  <= sel_word_id;
            gen_id_q   <= sel_gen_id;
            num_q      <= '0;
            hash_q     <= sel_hash;
            unit_ack_q <= pick_oh;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= 1'b1;
            state_q    <= S_SEND;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SEND: begin
          if (!out_full) begin
            wr_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // Hits preempt the pending done and restart the quiet count.
          if (any_valid) begin
            quiet_cnt_q <= '0;
            state_q     <= S_GRANT;
          end else if (!done_valid) begin
            quiet_cnt_q <= '0;
            state_q     <= S_IDLE;
          end else if (quiet && quiet_cnt_q == QUIET_LAST) begin
            type_q      <= TYPE_DONE;
            pkt_id_q    <= done_pkt_id;
            word_id_q   <= '0;
            gen_id_q    <= '0;
            num_q       <= done_num;
            hash_q      <= '0;
            done_ack_q  <= 1'b1;
            wr_en_q     <= 1'b1;
            quiet_cnt_q <= '0;
            state_q     <= S_SEND;
          end else begin
            quiet_cnt_q <= quiet_cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unit_ack      = unit_ack_q;
  assign done_ack      = done_ack_q;
  assign out_wr_en     = wr_en_q;
  assign pkt_type      = type_q;
  assign pkt_id        = pkt_id_q;
  assign word_id       = word_id_q;
  assign gen_id        = gen_id_q;
  assign num_processed = num_q;
  assign hash_num_eq   = hash_q;

endmodule

// File: tb/tb_outpkt_result_arbiter.sv
// Scoreboard bench for outpkt_result_arbiter: unit models feed hits,
// a monitor pops expected builder writes and compares.
module tb_outpkt_result_arbiter;
  import outpkt_result_arbiter_pkg::*;

  localparam int N = 8;

  typedef struct packed {
    logic [15:0] pid;
    logic [15:0] wid;
    logic [31:0] gid;
    logic [4:0]  hash;
  } hit_t;

  typedef struct packed {
    logic [1:0]  t;
    logic [15:0] pid;
    logic [15:0] wid;
    logic [31:0] gid;
    logic [31:0] num;
    logic [4:0]  hash;
  } item_t;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  unit_valid = '0;
  logic [N-1:0]  unit_ack;
  logic [16*N-1:0] unit_pkt_id = '0;
  logic [16*N-1:0] unit_word_id = '0;
  logic [32*N-1:0] unit_gen_id = '0;
  logic [5*N-1:0]  unit_hash_num = '0;
  logic [N-1:0]  unit_idle = '1;
  logic          done_valid = 1'b0;
  logic [15:0]   done_pkt_id = '0;
  logic [31:0]   done_num = '0;
  logic          done_ack;
  logic          out_full = 1'b0;
  logic          out_wr_en;
  logic [1:0]    pkt_type;
  logic [15:0]   pkt_id;
  logic [15:0]   word_id;
  logic [31:0]   gen_id;
  logic [31:0]   num_processed;
  logic [4:0]    hash_num_eq;

  hit_t  hq [N][16];
  int    hq_wr [N];
  int    hq_rd [N];
  item_t sb [64];
  int    sb_wr = 0;
  int    sb_rd = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 CLK = ~CLK;

  outpkt_result_arbiter dut (
    .CLK           (CLK),
    .rst           (rst),
    .unit_valid    (unit_valid),
    .unit_ack      (unit_ack),
    .unit_pkt_id   (unit_pkt_id),
    .unit_word_id  (unit_word_id),
    .unit_gen_id   (unit_gen_id),
    .unit_hash_num (unit_hash_num),
    .unit_idle     (unit_idle),
    .done_valid    (done_valid),
    .done_pkt_id   (done_pkt_id),
    .done_num      (done_num),
    .done_ack      (done_ack),
    .out_full      (out_full),
    .out_wr_en     (out_wr_en),
    .pkt_type      (pkt_type),
    .pkt_id        (pkt_id),
    .word_id       (word_id),
    .gen_id        (gen_id),
    .num_processed (num_processed),
    .hash_num_eq   (hash_num_eq)
  );

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic hit_t mk(input int u, input int k);
    hit_t h;
    h.pid  = 16'(16'h0100 * u + k);
    h.wid  = 16'(16'h1000 + 16 * u + k);
    h.gid  = 32'hC0DE0000 ^ 32'(u * 256 + k);
    h.hash = 5'((u + k) & 31);
    return h;
  endfunction

  task automatic push_hit(input int u, input hit_t h, input bit exp);
    hq[u][hq_wr[u] % 16] = h;
    hq_wr[u]++;
    if (exp) begin
      sb[sb_wr % 64] = {2'b01, h.pid, h.wid, h.gid, 32'h0, h.hash};
      sb_wr++;
    end
  endtask

  task automatic push_done(input logic [15:0] p, input logic [31:0] n);
    sb[sb_wr % 64] = {2'b10, p, 16'h0, 32'h0, n, 5'h0};
    sb_wr++;
  endtask

  function automatic int pending();
    int s = sb_wr - sb_rd;
    for (int i = 0; i < N; i++) s += hq_wr[i] - hq_rd[i];
    return s;
  endfunction

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(posedge CLK); #2;
      out_full = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
    end
    out_full = 1'b0;
    chk("drain_timeout", 128'(n >= budget), 0);
    repeat (2) @(posedge CLK);
    #2;
  endtask

  // Unit models: hold the head hit until its ack pulse is seen.
  initial begin
    logic [N-1:0] a;
    hit_t h;
    for (int i = 0; i < N; i++) begin
      hq_rd[i] = 0;
    end
    forever begin
      @(negedge CLK);
      a = unit_ack;
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) begin
        if (a[i] && hq_rd[i] != hq_wr[i]) hq_rd[i]++;
        if (hq_rd[i] != hq_wr[i]) begin
          h = hq[i][hq_rd[i] % 16];
          unit_valid[i] = 1'b1;
        end else begin
          h = '0;
          unit_valid[i] = 1'b0;
        end
        unit_pkt_id[i*16 +: 16]  = h.pid;
        unit_word_id[i*16 +: 16] = h.wid;
        unit_gen_id[i*32 +: 32]  = h.gid;
        unit_hash_num[i*5 +: 5]  = h.hash;
      end
    end
  end

  // Monitor: pop expected item on each builder transfer.
  initial begin
    item_t g;
    item_t hv;
    bit    held;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge CLK);
      g = {pkt_type, pkt_id, word_id, gen_id, num_processed, hash_num_eq};
      if (unit_ack != '0) chk("ack_onehot", 128'($countones(unit_ack)), 1);
      if (out_wr_en && held) chk("hold_stable", g, hv);
      if (out_wr_en && !out_full) begin
        if (sb_rd == sb_wr) begin
          chk("unexpected_out", g, 0);
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got item %0h want none", g);
        end else begin
          chk("out_item", g, sb[sb_rd % 64]);
          sb_rd++;
        end
      end
      held = out_wr_en && out_full;
      hv   = g;
    end
  end

  initial begin
    hit_t h;
    int   n;
    for (int i = 0; i < N; i++) hq_wr[i] = 0;

    for (int k = 0; k < 2; k++)
      for (int u = 0; u < N; u++) push_hit(u, mk(u, k), 1'b1);
    repeat (5) begin
      @(posedge CLK); #2;
      chk("rst_ack", unit_ack, 0);
      chk("rst_wr_en", out_wr_en, 0);
    end
    chk("rst_fields",
        {pkt_type, pkt_id, word_id, gen_id, num_processed, hash_num_eq}, 0);
    chk("rst_done_ack", done_ack, 0);
    rst = 1'b0;
    n = 0;
    while (unit_ack == '0 && n < 10) begin
      @(posedge CLK); #2;
      n++;
    end
    chk("first_grant", unit_ack, 8'h01);
    chk("first_grant_lat", n, 2);
    drain(600, 1'b1);

    h.pid = 16'h0012; h.wid = 16'h0034;
    h.gid = 32'hDEADBEEF; h.hash = 5'd5;
    @(negedge CLK);
    push_hit(3, h, 1'b1);
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("t2_early_wr", out_wr_en, 0);
    @(posedge CLK); #2;
    chk("t2_wr_en", out_wr_en, 1);
    chk("t2_ack", unit_ack, 8'h08);
    @(posedge CLK); #2;
    chk("t2_ack_pulse", unit_ack, 0);
    drain(50, 1'b0);

    unit_idle   = 8'hDF;
    done_pkt_id = 16'h0007;
    done_num    = 32'h00010000;
    push_done(16'h0007, 32'h00010000);
    done_valid  = 1'b1;
    repeat (10) begin
      @(posedge CLK); #2;
      chk("t4_busy_hold", {done_ack, out_wr_en}, 0);
    end
    unit_idle = '1;
    repeat (3) begin
      @(posedge CLK); #2;
      chk("t4_quiet_wait", done_ack, 0);
    end
    @(posedge CLK); #2;
    chk("t4_done_ack", done_ack, 1);
    chk("t4_wr_en", out_wr_en, 1);
    done_valid = 1'b0;
    drain(50, 1'b0);

    done_pkt_id = 16'h0008;
    done_num    = 32'h00000020;
    done_valid  = 1'b1;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    n = 2;
    @(negedge CLK);
    push_hit(2, mk(2, 5), 1'b1);
    push_done(16'h0008, 32'h00000020);
    while (!done_ack && n < 40) begin
      @(posedge CLK); #2;
      n++;
    end
    chk("t5_done_lat", n, 11);
    done_valid = 1'b0;
    drain(50, 1'b0);

    out_full = 1'b1;
    @(negedge CLK);
    push_hit(6, mk(6, 1), 1'b0);
    n = 0;
    while (!out_wr_en && n < 10) begin
      @(posedge CLK); #2;
      n++;
    end
    chk("t6_wr_en", out_wr_en, 1);
    chk("t6_ack", unit_ack, 8'h40);
    @(posedge CLK); #2;
    rst = 1'b1;
    @(posedge CLK); #2;
    rst = 1'b0;
    chk("t6_rst_wr_en", out_wr_en, 0);
    chk("t6_rst_type", pkt_type, 0);
    out_full = 1'b0;
    @(negedge CLK);
    push_hit(1, mk(1, 9), 1'b1);
    push_hit(7, mk(7, 9), 1'b1);
    drain(50, 1'b0);
    chk("final_wr_en", out_wr_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
